// File: rtl/sram_mem_ctrl.sv
// Multi-cycle MEM-stage data memory controller for an external narrow SRAM.
// Each DATA_W access is split into SRAM beats; ready doubles as the pipeline freeze.
`timescale 1ns/1ps
module sram_mem_ctrl #(
    parameter int          DATA_W      = 32,
    parameter int          SRAM_DATA_W = 16,
    parameter int          SRAM_ADDR_W = 18,
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    localparam int BEATS = DATA_W / SRAM_DATA_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(WAIT_CYCLES);
    localparam int SHIFT = $clog2(DATA_W / 8);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [BW-1:0]          beat;
    logic [CW-1:0]          cnt;
    logic                   op_wr;
    logic [DATA_W-1:0]      wbuf;
    logic                   req;
    logic                   beat_end;
    logic [31:0]            offset;
    logic [31:0]            word;
    logic [SRAM_ADDR_W-1:0] base_sram;

    assign req       = rd_en | wr_en;
    assign offset    = address - BASE_ADDR;
    assign word      = offset >> SHIFT;
    // Truncation gives the modulo wrap of the SRAM address space.
    assign base_sram = SRAM_ADDR_W'(word * 32'(BEATS));
    assign beat_end  = (state == ACCESS) && (cnt == LAST_CNT);

    always_comb begin
        state_next  = state;
        ready       = 1'b1;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        unique case (state)
            IDLE: begin
                ready = ~req;
                if (req) state_next = ACCESS;
            end
            ACCESS: begin
                ready = 1'b0;
                if (beat_end && beat == LAST_BEAT)
                    state_next = DONE;
                if (op_wr) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wbuf[beat*SRAM_DATA_W +: SRAM_DATA_W];
                    // Strobe stays high on first/last clock for setup and hold.
                    sram_we_n   = (cnt == '0) || (cnt == LAST_CNT);
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            beat      <= '0;
            cnt       <= '0;
            op_wr     <= 1'b0;
            wbuf      <= '0;
            rdata     <= '0;
            sram_addr <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req) begin
                op_wr     <= wr_en;
                wbuf      <= wdata;
                beat      <= '0;
                cnt       <= '0;
                sram_addr <= base_sram;
            end else if (state == ACCESS) begin
                if (beat_end) begin
                    cnt <= '0;
                    if (!op_wr)
                        rdata[beat*SRAM_DATA_W +: SRAM_DATA_W] <= sram_dq_in;
                    if (beat != LAST_BEAT) begin
                        beat      <= beat + 1'b1;
                        sram_addr <= sram_addr + 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: default build plus a one-beat,
// three-wait-cycle build, each with a small SRAM model.
`timescale 1ns/1ps
module tb_sram_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, wdata, rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;
    logic        dq_oe, we_n, oe_n;

    logic        wr2, rd2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        ready2;
    logic [17:0] sa2;
    logic [31:0] do2, di2;
    logic        oe2, we2_n, oen2;

    sram_mem_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .wdata(wdata), .rdata(rdata),
        .ready(ready), .sram_addr(sram_addr),
        .sram_dq_out(dq_out), .sram_dq_oe(dq_oe),
        .sram_dq_in(dq_in), .sram_we_n(we_n), .sram_oe_n(oe_n)
    );

    sram_mem_ctrl #(.WAIT_CYCLES(3), .SRAM_DATA_W(32)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(rd2),
        .address(addr2), .wdata(wdata2), .rdata(rdata2),
        .ready(ready2), .sram_addr(sa2),
        .sram_dq_out(do2), .sram_dq_oe(oe2),
        .sram_dq_in(di2), .sram_we_n(we2_n), .sram_oe_n(oen2)
    );

    logic [15:0] mem  [64];
    logic [31:0] mem2 [64];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]  = '0;
            mem2[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (!we_n && dq_oe) mem[sram_addr[5:0]] <= dq_out;
        if (!we2_n && oe2) mem2[sa2[5:0]] <= do2;
    end

    assign dq_in = !oe_n ? mem[sram_addr[5:0]] : '0;
    assign di2   = !oen2 ? mem2[sa2[5:0]] : '0;

    typedef struct {
        logic [31:0] rd;
        int          low;
        int          wel;
        bit          wr;
        int          a0;
        logic [31:0] d0;
        int          a1;
        logic [31:0] d1;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   total = 0;
    int   bad = 0;
    int   low1 = 0, wel1 = 0;
    int   low2 = 0, wel2 = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic exp_t mk(logic [31:0] rd, int low, int wel, bit wr,
                                int a0, logic [31:0] d0,
                                int a1, logic [31:0] d1);
        exp_t e;
        e.rd = rd; e.low = low; e.wel = wel; e.wr = wr;
        e.a0 = a0; e.d0 = d0; e.a1 = a1; e.d1 = d1;
        return e;
    endfunction

    // A completed access is a rising ready after at least one frozen cycle.
    always @(negedge clk) begin
        if (!rst) begin
            low1 = 0;
            wel1 = 0;
        end else if (!ready) begin
            low1++;
            if (!we_n) wel1++;
        end else if (low1 > 0) begin
            if (q1.size() == 0) begin
                check("unexpected_access", 32'(low1), 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("rdata", rdata, e1.rd);
                check("latency", 32'(low1), 32'(e1.low));
                check("we_low", 32'(wel1), 32'(e1.wel));
                if (e1.wr) begin
                    check("mem_beat0", 32'(mem[e1.a0]), e1.d0);
                    check("mem_beat1", 32'(mem[e1.a1]), e1.d1);
                end
            end
            low1 = 0;
            wel1 = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            low2 = 0;
            wel2 = 0;
        end else if (!ready2) begin
            low2++;
            if (!we2_n) wel2++;
        end else if (low2 > 0) begin
            if (q2.size() == 0) begin
                check("unexpected_access2", 32'(low2), 32'd0);
            end else begin
                e2 = q2.pop_front();
                check("rdata2", rdata2, e2.rd);
                check("latency2", 32'(low2), 32'(e2.low));
                check("we_low2", 32'(wel2), 32'(e2.wel));
                if (e2.wr) check("mem2", mem2[e2.a0], e2.d0);
            end
            low2 = 0;
            wel2 = 0;
        end
    end

    task automatic wait_done(bit second);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(second ? ready2 : ready) && n < 100);
        check("done_seen", 32'(second ? ready2 : ready), 32'd1);
    endtask

    task automatic access(bit w, bit r, logic [31:0] a, logic [31:0] d,
                          exp_t e, bit hold);
        @(posedge clk);
        #1;
        wr_en = w; rd_en = r; address = a; wdata = d;
        q1.push_back(e);
        wait_done(1'b0);
        if (!hold) begin
            @(posedge clk);
            #1;
            wr_en = 1'b0; rd_en = 1'b0;
        end
    endtask

    task automatic access2(bit w, bit r, logic [31:0] a, logic [31:0] d,
                           exp_t e);
        @(posedge clk);
        #1;
        wr2 = w; rd2 = r; addr2 = a; wdata2 = d;
        q2.push_back(e);
        wait_done(1'b1);
        @(posedge clk);
        #1;
        wr2 = 1'b0; rd2 = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_rdata", rdata, 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(dq_out), 32'd0);
        check("rst_dq_oe", 32'(dq_oe), 32'd0);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0;
        wr2 = 1'b0; rd2 = 1'b0; addr2 = '0; wdata2 = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        check("rst_ready2", 32'(ready2), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;

        // Abort a read part-way through with reset.
        @(posedge clk);
        #1;
        rd_en = 1'b1; address = 32'd1028;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0; rd_en = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(ready), 32'd1);

        access(1, 0, 32'd1028, 32'hDEAD_BEEF,
               mk(32'd0, 11, 6, 1, 2, 32'hBEEF, 3, 32'hDEAD), 0);
        check("addr_hold", 32'(sram_addr), 32'd3);

        access(0, 1, 32'd1028, 32'd0,
               mk(32'hDEAD_BEEF, 11, 0, 0, 0, 0, 0, 0), 0);
        @(negedge clk);
        check("rdata_idle_hold", rdata, 32'hDEAD_BEEF);

        access(1, 1, 32'd1024, 32'h1234_5678,
               mk(32'hDEAD_BEEF, 11, 6, 1, 0, 32'h5678, 1, 32'h1234), 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'd1);
        end

        // Request kept asserted across DONE into the next IDLE cycle.
        access(1, 0, 32'd1032, 32'hAAAA_5555,
               mk(32'hDEAD_BEEF, 11, 6, 1, 4, 32'h5555, 5, 32'hAAAA), 1);
        access(0, 1, 32'd1032, 32'd0,
               mk(32'hAAAA_5555, 11, 0, 0, 0, 0, 0, 0), 0);

        access2(1, 0, 32'd1044, 32'hCAFE_F00D,
                mk(32'd0, 4, 1, 1, 5, 32'hCAFE_F00D, 5, 32'hCAFE_F00D));
        check("sweep_addr", 32'(sa2), 32'd5);
        access2(0, 1, 32'd1044, 32'd0,
                mk(32'hCAFE_F00D, 4, 0, 0, 0, 0, 0, 0));

        repeat (3) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
